// File: rtl/ic_pkg.sv
// ---------------------------------------------------------------------------
// ic_pkg
// Shared types and constants for the closest-hit reduction block.
//   hit_rec_t   : one reduced per-ray record as stored in the output FIFO
//   FLT_POS_INF : IEEE-754 single +infinity, reported as t when a ray has no hit
//   T_MIN_DEF   : default self-intersection epsilon (0.001f)
//   REC_IDX_W   : width of the idx field carried in hit_rec_t
//   fsm_t       : reduction FSM states
// ---------------------------------------------------------------------------
package ic_pkg;

  localparam logic [31:0] FLT_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] T_MIN_DEF   = 32'h3A83_126F;

  // The record's idx field is fixed-width; the top-level IDX_W must not exceed it.
  localparam int REC_IDX_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fsm_t;

  typedef struct packed {
    logic [31:0]          sid;
    logic                 hit;
    logic [31:0]          t;
    logic [95:0]          point;
    logic [95:0]          norm;
    logic [REC_IDX_W-1:0] idx;
  } hit_rec_t;

endpackage

// File: rtl/hit_rec_fifo.sv
// ---------------------------------------------------------------------------
// hit_rec_fifo
// Synchronous FIFO of hit_rec_t records with registered storage. The head
// entry is always visible on rd_data; pop advances it.
// A push while full is accepted only when a pop happens in the same cycle,
// otherwise it is ignored (the caller flags the drop).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write wr_data this cycle
//   wr_data    : record to write
//   pop        : consume the head entry (ignored when empty)
//   rd_data    : head entry
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module hit_rec_fifo
  import ic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  hit_rec_t                 wr_data,
  input  logic                     pop,
  output hit_rec_t                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  hit_rec_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // When full, the same-cycle pop frees the slot the write pointer sits on.
  assign do_push = push && (!full || do_pop);

  // Storage carries data only; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/closest_hit_select.sv
// ---------------------------------------------------------------------------
// closest_hit_select
// Reduces the per-triangle intersection results of each ray to the nearest
// qualified hit and queues one record per ray toward shading/writeback.
// Input beats cannot be stalled; a full FIFO drops the record and raises
// the sticky overflow flag.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   in_valid      : intersection result valid this cycle
//   in_last       : final triangle of the current ray
//   in_sid        : ray/shader id
//   in_hit        : hit flag from the intersection pipeline
//   in_t          : float distance
//   in_point      : {x,y,z} float intersection point
//   in_norm       : {x,y,z} float unnormalised normal
//   out_valid     : FIFO head valid
//   out_ready     : consumer accepts head
//   out_sid       : ray id
//   out_hit       : a qualified hit was found for the ray
//   out_t         : nearest t, +inf when no hit
//   out_point     : point of the nearest hit, 0 when no hit
//   out_norm      : normal of the nearest hit, 0 when no hit
//   out_idx       : arrival index of the winner within its ray, all-ones when no hit
//   overflow      : sticky, a record was dropped on a full FIFO
//   seq_err       : sticky, sid changed mid-ray without in_last
// ---------------------------------------------------------------------------
module closest_hit_select
  import ic_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] T_MIN      = T_MIN_DEF,
  parameter int          IDX_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [31:0]      in_sid,
  input  logic             in_hit,
  input  logic [31:0]      in_t,
  input  logic [95:0]      in_point,
  input  logic [95:0]      in_norm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sid,
  output logic             out_hit,
  output logic [31:0]      out_t,
  output logic [95:0]      out_point,
  output logic [95:0]      out_norm,
  output logic [IDX_W-1:0] out_idx,
  output logic             overflow,
  output logic             seq_err
);

  localparam logic [IDX_W-1:0] IDX_NONE = '1;
  localparam logic [IDX_W-1:0] IDX_SAT  = IDX_NONE - IDX_W'(1);

  // Positive, finite and strictly beyond epsilon. For non-negative floats the
  // magnitude bits order the same way as the values, so an integer compare works.
  function automatic logic qualify(input logic hit, input logic [31:0] t);
    return hit && !t[31] && (t[30:23] != 8'hFF) && (t[30:0] > T_MIN[30:0]);
  endfunction

  // Stops one short of all-ones, which stays reserved for "no hit".
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v >= IDX_SAT) ? v : v + IDX_W'(1);
  endfunction

  fsm_t             state_q;
  fsm_t             state_d;
  logic [31:0]      cur_sid_q;
  logic [IDX_W-1:0] idx_q;
  logic             best_vld_q;
  logic [31:0]      best_t_q;
  logic [95:0]      best_point_q;
  logic [95:0]      best_norm_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             seq_err_q;
  logic             overflow_q;

  logic             beat_qual;
  logic             sid_switch;
  logic             open_beat;
  logic             base_vld;
  logic [IDX_W-1:0] beat_idx;
  logic             take;
  logic             mrg_vld;
  logic [31:0]      mrg_t;
  logic [95:0]      mrg_point;
  logic [95:0]      mrg_norm;
  logic [IDX_W-1:0] mrg_idx;

  logic             push;
  logic             seq_err_set;
  hit_rec_t         push_rec;

  logic             pop;
  hit_rec_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic             unused_fifo_count;

  // ---- beat qualification and merge with the running best ----
  assign beat_qual  = qualify(in_hit, in_t);
  assign sid_switch = (state_q == ACCUM) && (in_sid != cur_sid_q);
  // A sid switch abandons the open ray and restarts from this beat.
  assign open_beat  = (state_q == IDLE) || sid_switch;
  assign base_vld   = open_beat ? 1'b0 : best_vld_q;
  assign beat_idx   = open_beat ? '0 : idx_q;
  // Strict less-than: on a tie the earlier triangle wins.
  assign take       = beat_qual && (!base_vld || (in_t[30:0] < best_t_q[30:0]));

  assign mrg_vld    = take || base_vld;
  assign mrg_t      = take ? in_t     : best_t_q;
  assign mrg_point  = take ? in_point : best_point_q;
  assign mrg_norm   = take ? in_norm  : best_norm_q;
  assign mrg_idx    = take ? beat_idx : best_idx_q;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      state_d = in_last ? IDLE : ACCUM;
    end
  end

  // ---- FSM: outputs (close record, error strobe) ----
  always_comb begin
    push        = in_valid && in_last;
    seq_err_set = in_valid && sid_switch;
    push_rec    = '0;
    push_rec.sid = in_sid;
    push_rec.hit = mrg_vld;
    if (mrg_vld) begin
      push_rec.t     = mrg_t;
      push_rec.point = mrg_point;
      push_rec.norm  = mrg_norm;
      push_rec.idx   = REC_IDX_W'(mrg_idx);
    end else begin
      push_rec.t     = FLT_POS_INF;
      push_rec.idx   = REC_IDX_W'(IDX_NONE);
    end
  end

  // ---- per-ray accumulation registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sid_q    <= '0;
      idx_q        <= '0;
      best_vld_q   <= 1'b0;
      best_t_q     <= '0;
      best_point_q <= '0;
      best_norm_q  <= '0;
      best_idx_q   <= '0;
    end else if (in_valid) begin
      if (in_last) begin
        idx_q        <= '0;
        best_vld_q   <= 1'b0;
        best_t_q     <= '0;
        best_point_q <= '0;
        best_norm_q  <= '0;
        best_idx_q   <= '0;
      end else begin
        cur_sid_q    <= in_sid;
        idx_q        <= open_beat ? IDX_W'(1) : sat_inc(idx_q);
        best_vld_q   <= mrg_vld;
        best_t_q     <= mrg_t;
        best_point_q <= mrg_point;
        best_norm_q  <= mrg_norm;
        best_idx_q   <= mrg_idx;
      end
    end
  end

  // ---- sticky status ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (seq_err_set) begin
        seq_err_q <= 1'b1;
      end
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---- output queue ----
  assign pop = out_valid && out_ready;

  hit_rec_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_rec),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  // Idle values are forced whenever the queue is empty so stale storage never leaks out.
  always_comb begin
    out_valid = !fifo_empty;
    out_sid   = '0;
    out_hit   = 1'b0;
    out_t     = FLT_POS_INF;
    out_point = '0;
    out_norm  = '0;
    out_idx   = IDX_NONE;
    if (!fifo_empty) begin
      out_sid   = head.sid;
      out_hit   = head.hit;
      out_t     = head.t;
      out_point = head.point;
      out_norm  = head.norm;
      out_idx   = head.idx[IDX_W-1:0];
    end
  end

  assign overflow = overflow_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_closest_hit_select.sv
// ---------------------------------------------------------------------------
// tb_closest_hit_select
// Directed bench: a table of input beats with hand-computed expected output
// records, followed by hand-written backpressure, full-FIFO, sid-switch and
// mid-ray reset sequences.
// ---------------------------------------------------------------------------
module tb_closest_hit_select;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_sid;
  logic        in_hit;
  logic [31:0] in_t;
  logic [95:0] in_point;
  logic [95:0] in_norm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sid;
  logic        out_hit;
  logic [31:0] out_t;
  logic [95:0] out_point;
  logic [95:0] out_norm;
  logic [15:0] out_idx;
  logic        overflow;
  logic        seq_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INF = 32'h7F80_0000;

  closest_hit_select #(
    .FIFO_DEPTH (4),
    .T_MIN      (32'h3A83_126F),
    .IDX_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_sid    (in_sid),
    .in_hit    (in_hit),
    .in_t      (in_t),
    .in_point  (in_point),
    .in_norm   (in_norm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sid   (out_sid),
    .out_hit   (out_hit),
    .out_t     (out_t),
    .out_point (out_point),
    .out_norm  (out_norm),
    .out_idx   (out_idx),
    .overflow  (overflow),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        last;
    logic [31:0] sid;
    logic        hit;
    logic [31:0] t;
    logic        exp_vld;
    logic [31:0] exp_sid;
    logic        exp_hit;
    logic [31:0] exp_t;
    logic [15:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  // Point and normal are tagged from t so the winning triangle's payload is recognisable.
  function automatic logic [95:0] pt(input logic [31:0] t);
    return {t, ~t, t ^ 32'h5555_5555};
  endfunction

  function automatic logic [95:0] nm(input logic [31:0] t);
    return {~t, t ^ 32'h0F0F_0F0F, t};
  endfunction

  task automatic add(input logic vld, input logic last, input logic [31:0] sid,
                     input logic hit, input logic [31:0] t, input logic ev,
                     input logic [31:0] es, input logic eh, input logic [31:0] et,
                     input logic [15:0] ei);
    vec_t v;
    v.vld = vld; v.last = last; v.sid = sid; v.hit = hit; v.t = t;
    v.exp_vld = ev; v.exp_sid = es; v.exp_hit = eh; v.exp_t = et; v.exp_idx = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [31:0] sid, input logic hit, input logic [31:0] t,
                      input logic last);
    in_valid = 1'b1;
    in_last  = last;
    in_sid   = sid;
    in_hit   = hit;
    in_t     = t;
    in_point = pt(t);
    in_norm  = nm(t);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_t"},     out_t, INF);
    chk({tag, "_idx"},   out_idx, 16'hFFFF);
    chk({tag, "_sid"},   out_sid, 32'h0);
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    in_sid    = '0;
    in_hit    = 1'b0;
    in_t      = '0;
    in_point  = '0;
    in_norm   = '0;
    idle();

    // vld last sid hit t | exp_vld sid hit t idx
    add(1, 1,  5, 1, 32'h4000_0000,  1,  5, 1, 32'h4000_0000, 16'h0000);
    add(1, 0,  9, 1, 32'h4040_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 0,  9, 1, 32'h3F80_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 0,  9, 1, 32'h3F80_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 1,  9, 1, 32'h4000_0000,  1,  9, 1, 32'h3F80_0000, 16'h0001);
    add(1, 0,  7, 0, 32'h3F00_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 0,  7, 1, 32'hBF80_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 0,  7, 1, 32'h3A03_126F,  0,  0, 0, INF,           16'hFFFF);
    add(1, 1,  7, 1, 32'h7FC0_0000,  1,  7, 0, INF,           16'hFFFF);
    add(1, 0, 11, 1, 32'h3A83_126F,  0,  0, 0, INF,           16'hFFFF);
    add(1, 0, 11, 1, 32'h7F80_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 1, 11, 1, 32'h3A83_1270,  1, 11, 1, 32'h3A83_1270, 16'h0002);
    add(1, 0, 12, 1, 32'h4000_0000,  0,  0, 0, INF,           16'hFFFF);
    add(0, 0, 12, 1, 32'h3E80_0000,  0,  0, 0, INF,           16'hFFFF);
    add(1, 1, 12, 1, 32'h3F80_0000,  1, 12, 1, 32'h3F80_0000, 16'h0001);
    add(1, 1, 13, 0, 32'h3F80_0000,  1, 13, 0, INF,           16'hFFFF);
    add(0, 0,  0, 0, 32'h0000_0000,  0,  0, 0, INF,           16'hFFFF);

    // Reset state
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_hit",      out_hit, 1'b0);
    chk("reset_point",    out_point, 96'h0);
    chk("reset_norm",     out_norm, 96'h0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_seq_err",  seq_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven beats, one per cycle, consumer always ready
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].vld) beat(vecs[i].sid, vecs[i].hit, vecs[i].t, vecs[i].last);
      else             idle();
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), out_valid, vecs[i].exp_vld);
      if (vecs[i].exp_vld) begin
        chk($sformatf("row%0d_sid", i),   out_sid, vecs[i].exp_sid);
        chk($sformatf("row%0d_hit", i),   out_hit, vecs[i].exp_hit);
        chk($sformatf("row%0d_t", i),     out_t, vecs[i].exp_t);
        chk($sformatf("row%0d_idx", i),   out_idx, vecs[i].exp_idx);
        chk($sformatf("row%0d_point", i), out_point, vecs[i].exp_hit ? pt(vecs[i].exp_t) : 96'h0);
        chk($sformatf("row%0d_norm", i),  out_norm, vecs[i].exp_hit ? nm(vecs[i].exp_t) : 96'h0);
      end else begin
        chk($sformatf("row%0d_idle_t", i),   out_t, INF);
        chk($sformatf("row%0d_idle_idx", i), out_idx, 16'hFFFF);
      end
    end
    idle();
    chk("table_overflow", overflow, 1'b0);
    chk("table_seq_err",  seq_err, 1'b0);

    // Backpressure: five closes into a four-deep queue
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(32'd20 + 32'(k), 1'b1, 32'h4000_0000, 1'b1);
      @(negedge clk);
    end
    idle();
    chk("bp_valid",    out_valid, 1'b1);
    chk("bp_overflow", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain%0d_sid", k), out_sid, 32'd20 + 32'(k));
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_empty_valid", out_valid, 1'b0);
    chk("bp_overflow_sticky", overflow, 1'b1);

    // Full queue with simultaneous pop and push
    do_reset();
    chk("rst_clears_overflow", overflow, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(32'd30 + 32'(k), 1'b1, 32'h4000_0000, 1'b1);
      @(negedge clk);
    end
    beat(32'd34, 1'b1, 32'h4000_0000, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    chk("full_pp_overflow", overflow, 1'b0);
    chk("full_pp_head",     out_sid, 32'd31);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_pp_drain%0d_sid", k), out_sid, 32'd31 + 32'(k));
      chk($sformatf("full_pp_drain%0d_valid", k), out_valid, 1'b1);
      @(negedge clk);
    end
    chk("full_pp_empty", out_valid, 1'b0);

    // Sid changes mid-ray without last
    do_reset();
    beat(32'd3, 1'b1, 32'h3F80_0000, 1'b0);
    @(negedge clk);
    chk("seq_err_before", seq_err, 1'b0);
    beat(32'd4, 1'b1, 32'h4000_0000, 1'b0);
    @(negedge clk);
    chk("seq_err_set",   seq_err, 1'b1);
    chk("seq_err_valid", out_valid, 1'b0);
    beat(32'd4, 1'b1, 32'h4040_0000, 1'b1);
    @(negedge clk);
    idle();
    chk("seq_rec_valid", out_valid, 1'b1);
    chk("seq_rec_sid",   out_sid, 32'd4);
    chk("seq_rec_t",     out_t, 32'h4000_0000);
    chk("seq_rec_idx",   out_idx, 16'h0000);
    @(negedge clk);
    chk("seq_only_one", out_valid, 1'b0);
    chk("seq_err_sticky", seq_err, 1'b1);

    // Reset asserted mid-ray with a record queued
    out_ready = 1'b0;
    beat(32'd40, 1'b1, 32'h4000_0000, 1'b1);
    @(negedge clk);
    beat(32'd50, 1'b1, 32'h3F80_0000, 1'b0);
    @(negedge clk);
    idle();
    chk("mid_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    chk("mid_rst_seq_err", seq_err, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    beat(32'd51, 1'b1, 32'h4040_0000, 1'b1);
    @(negedge clk);
    idle();
    chk("post_rst_sid", out_sid, 32'd51);
    chk("post_rst_t",   out_t, 32'h4040_0000);
    chk("post_rst_idx", out_idx, 16'h0000);
    @(negedge clk);
    chk("post_rst_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
